// File: rtl/triangle_generator.sv
// triangle_generator: steps a level between 0 and max_value on each accepted
// step pulse, dwelling HOLD extra steps at peak and trough, and drives a PWM
// output whose duty cycle follows the level.
module triangle_generator #(
  parameter int N    = 8,
  parameter int HOLD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         step,
  input  logic [N-1:0] max_value,
  output logic [N-1:0] level,
  output logic         rising,
  output logic         cycle_done,
  output logic         pwm
);

  typedef enum logic [1:0] {
    UP          = 2'd0,
    HOLD_TOP    = 2'd1,
    DOWN        = 2'd2,
    HOLD_BOTTOM = 2'd3
  } state_t;

  localparam logic [N-1:0] ONE     = N'(1);
  localparam logic [N-1:0] ZERO    = '0;
  localparam logic [7:0]   HOLD_C  = 8'(HOLD);
  localparam bit           NO_HOLD = (HOLD == 0);

  state_t       state;
  logic [7:0]   hold_cnt;
  logic [N-1:0] pwm_cnt;

  // Triangle FSM: level, state, dwell counter, direction and period marker
  // only move on accepted steps; cycle_done is a one-clock pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= UP;
      level      <= ZERO;
      hold_cnt   <= 8'd0;
      rising     <= 1'b1;
      cycle_done <= 1'b0;
    end else if (ena) begin
      cycle_done <= 1'b0;
      if (step) begin
        if (level > max_value) begin
          // max_value dropped below the current level: snap to the new peak
          level <= max_value;
          if (NO_HOLD) begin
            state  <= DOWN;
            rising <= 1'b0;
          end else begin
            state    <= HOLD_TOP;
            hold_cnt <= 8'd1;
            rising   <= 1'b1;
          end
        end else if (max_value == ZERO) begin
          // Degenerate triangle: park at 0 and restart upward
          level  <= ZERO;
          state  <= UP;
          rising <= 1'b1;
        end else begin
          case (state)
            UP: begin
              if (level < max_value) begin
                level <= level + ONE;
              end else if (NO_HOLD) begin
                level  <= level - ONE;
                state  <= DOWN;
                rising <= 1'b0;
              end else begin
                state    <= HOLD_TOP;
                hold_cnt <= 8'd1;
              end
            end
            HOLD_TOP: begin
              if (hold_cnt == HOLD_C) begin
                level  <= level - ONE;
                state  <= DOWN;
                rising <= 1'b0;
              end else begin
                hold_cnt <= hold_cnt + 8'd1;
              end
            end
            DOWN: begin
              if (level != ZERO) begin
                level <= level - ONE;
              end else if (NO_HOLD) begin
                level      <= ONE;
                state      <= UP;
                rising     <= 1'b1;
                cycle_done <= 1'b1;
              end else begin
                state    <= HOLD_BOTTOM;
                hold_cnt <= 8'd1;
              end
            end
            HOLD_BOTTOM: begin
              if (hold_cnt == HOLD_C) begin
                level      <= ONE;
                state      <= UP;
                rising     <= 1'b1;
                cycle_done <= 1'b1;
              end else begin
                hold_cnt <= hold_cnt + 8'd1;
              end
            end
            default: begin
              state <= UP;
            end
          endcase
        end
      end
    end
  end

  // PWM: free-running counter compared against level; output forced low
  // while disabled, counter frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= ZERO;
      pwm     <= 1'b0;
    end else if (ena) begin
      pwm_cnt <= pwm_cnt + ONE;
      pwm     <= (pwm_cnt < level);
    end else begin
      pwm <= 1'b0;
    end
  end

endmodule

// File: tb/tb_triangle_generator.sv
// tb_triangle_generator: directed bench for triangle_generator with three
// instances (N=8/HOLD=0, N=8/HOLD=2, N=4/HOLD=0) and a queue scoreboard.
module tb_triangle_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       ena_a, step_a, rising_a, cd_a, pwm_a;
  logic [7:0] max_a, level_a;
  logic       ena_b, step_b, rising_b, cd_b, pwm_b;
  logic [7:0] max_b, level_b;
  logic       ena_c, step_c, rising_c, cd_c, pwm_c;
  logic [3:0] max_c, level_c;

  triangle_generator #(.N(8), .HOLD(0)) u_a (
    .clk(clk), .rst(rst), .ena(ena_a), .step(step_a), .max_value(max_a),
    .level(level_a), .rising(rising_a), .cycle_done(cd_a), .pwm(pwm_a));

  triangle_generator #(.N(8), .HOLD(2)) u_b (
    .clk(clk), .rst(rst), .ena(ena_b), .step(step_b), .max_value(max_b),
    .level(level_b), .rising(rising_b), .cycle_done(cd_b), .pwm(pwm_b));

  triangle_generator #(.N(4), .HOLD(0)) u_c (
    .clk(clk), .rst(rst), .ena(ena_c), .step(step_c), .max_value(max_c),
    .level(level_c), .rising(rising_c), .cycle_done(cd_c), .pwm(pwm_c));

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  int lv_a[14] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0, 1, 2};
  int lv_b[9]  = '{1, 2, 2, 2, 1, 0, 0, 0, 1};
  int rs_b[9]  = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0d expected=<empty scoreboard>", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  initial begin
    int cnt;

    // Reset with step and enable active on every instance
    rst = 1'b1;
    ena_a = 1'b1; step_a = 1'b1; max_a = 8'd3;
    ena_b = 1'b1; step_b = 1'b1; max_b = 8'd2;
    ena_c = 1'b1; step_c = 1'b1; max_c = 4'd5;
    tick();
    check("rst_level", level_a, 0);
    check("rst_pwm", pwm_a, 0);
    check("rst_cd", cd_a, 0);
    check("rst_rising", rising_a, 1);
    check("rst_level_b", level_b, 0);
    rst = 1'b0; step_a = 1'b0; step_b = 1'b0; step_c = 1'b0;

    // Basic triangle, max=3, HOLD=0, one step every 4 clocks
    cnt = 0;
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(lv_a[i]);
      exp_q.push_back((i == 6 || i == 12) ? 1 : 0);
      step_a = 1'b1;
      tick();
      step_a = 1'b0;
      check_pop($sformatf("triA_level[%0d]", i), level_a);
      check_pop($sformatf("triA_cd[%0d]", i), cd_a);
      cnt += int'(cd_a);
      for (int k = 0; k < 3; k++) begin
        tick();
        cnt += int'(cd_a);
      end
    end
    check("triA_cd_pulses", cnt, 2);

    // Dwell, HOLD=2, max=2, back-to-back steps
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(lv_b[i]);
      exp_q.push_back(rs_b[i]);
      exp_q.push_back((i == 8) ? 1 : 0);
      step_b = 1'b1;
      tick();
      check_pop($sformatf("dwell_level[%0d]", i), level_b);
      check_pop($sformatf("dwell_rising[%0d]", i), rising_b);
      check_pop($sformatf("dwell_cd[%0d]", i), cd_b);
    end
    step_b = 1'b0;
    tick();
    check("dwell_cd_drop", cd_b, 0);

    // Clamp with HOLD=0: climb to 8 then lower max to 5
    max_a = 8'd10;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(3 + i);
      step_a = 1'b1;
      tick();
      check_pop($sformatf("clampA_climb[%0d]", i), level_a);
    end
    max_a = 8'd5;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(5 - i);
      exp_q.push_back(0);
      tick();
      check_pop($sformatf("clampA_level[%0d]", i), level_a);
      check_pop($sformatf("clampA_rising[%0d]", i), rising_a);
    end
    step_a = 1'b0;

    // Clamp with HOLD=2: lands in HOLD_TOP and dwells
    max_b = 8'd10;
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(2 + i);
      step_b = 1'b1;
      tick();
      check_pop($sformatf("clampB_climb[%0d]", i), level_b);
    end
    max_b = 8'd5;
    exp_q.push_back(5); exp_q.push_back(1);
    exp_q.push_back(5); exp_q.push_back(1);
    exp_q.push_back(4); exp_q.push_back(0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_pop($sformatf("clampB_level[%0d]", i), level_b);
      check_pop($sformatf("clampB_rising[%0d]", i), rising_b);
    end
    step_b = 1'b0;

    // Enable freeze on instance A with steps present
    ena_a = 1'b0;
    step_a = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(pwm_a);
      check($sformatf("freeze_level[%0d]", i), level_a, 3);
    end
    check("freeze_pwm_high", cnt, 0);
    check("freeze_rising", rising_a, 0);
    ena_a = 1'b1;
    exp_q.push_back(2); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_pop($sformatf("resume_level[%0d]", i), level_a);
      check_pop($sformatf("resume_cd[%0d]", i), cd_a);
    end
    check("resume_rising", rising_a, 1);
    step_a = 1'b0;

    // PWM duty on N=4 instance: level 5
    step_c = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    step_c = 1'b0;
    check("pwm_level5", level_c, 5);
    tick(); tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt += int'(pwm_c);
    end
    check("pwm_duty5", cnt, 5);

    // PWM duty at full scale: level 15
    max_c = 4'd15;
    step_c = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    step_c = 1'b0;
    check("pwm_level15", level_c, 15);
    tick(); tick();
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      cnt += int'(pwm_c);
    end
    check("pwm_duty15", cnt, 15);

    // max_value=0 clamps level to 0; PWM never high
    max_c = 4'd0;
    step_c = 1'b1;
    tick();
    step_c = 1'b0;
    check("pwm_level0", level_c, 0);
    tick();
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      cnt += int'(pwm_c);
    end
    check("pwm_duty0", cnt, 0);

    // Mid-sequence reset returns instance A to reset values
    rst = 1'b1;
    step_a = 1'b1;
    tick();
    rst = 1'b0;
    step_a = 1'b0;
    check("rst2_level", level_a, 0);
    check("rst2_rising", rising_a, 1);
    check("rst2_pwm", pwm_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/triangle_generator.md
# triangle_generator

Steps an N-bit level up and down between 0 and `max_value`, advancing once per `step` pulse, and emits a PWM waveform whose duty cycle tracks that level. It sits directly downstream of the periodic pulse generator: that block's one-cycle `out` drives `step` here. The pair produces an LED-breathing waveform. A configurable dwell holds the level at the peak and the trough.

## Interface
- `N`, default 8: width of level, `max_value` and PWM counter.
- `HOLD`, default 0: extra steps to dwell at peak and trough. Legal range 0..255.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  global enable; when low, all state is frozen.
- `step`  in  1  one-cycle advance pulse from the pulse generator.
- `max_value`  in  N  peak level; sampled on every accepted step.
- `level`  out  N  current triangle level, registered.
- `rising`  out  1  high in states UP and HOLD_TOP, registered.
- `cycle_done`  out  1  one-clock pulse marking the start of a new period.
- `pwm`  out  1  PWM output, registered.

## Operation
- Reset values: `level`=0, state=UP, `hold_cnt`=0, `pwm_cnt`=0, `pwm`=0, `cycle_done`=0, `rising`=1. `rst` overrides `ena`.
- An accepted step is a clock edge with `ena`=1 and `step`=1. Only accepted steps change the state, `level` or `hold_cnt`. `step` pulses while `ena`=0 are lost.
- FSM states are UP, HOLD_TOP, DOWN and HOLD_BOTTOM. Transitions below happen on accepted steps only:
  - Priority 1, clamp (any state): if `level` > `max_value`, then `level` ← `max_value`. Next state is HOLD_TOP with `hold_cnt` ← 1, or DOWN if `HOLD`==0.
  - Priority 2, `max_value`==0: `level` stays 0, state ← UP, no `cycle_done`.
  - UP: if `level` < `max_value`, `level`+1. Otherwise (`level`==`max_value`): if `HOLD`==0, `level`−1 and go to DOWN; else go to HOLD_TOP with `hold_cnt` ← 1 and `level` unchanged.
  - HOLD_TOP: if `hold_cnt`==`HOLD`, `level`−1 and go to DOWN; else `hold_cnt`+1.
  - DOWN: if `level` > 0, `level`−1. At 0: if `HOLD`==0, `level`+1 and go to UP; else go to HOLD_BOTTOM with `hold_cnt` ← 1.
  - HOLD_BOTTOM: if `hold_cnt`==`HOLD`, `level`+1 and go to UP; else `hold_cnt`+1.
- Resulting sequence: the peak and trough values each last `HOLD`+1 steps. Period is 2·`max_value`+2·`HOLD` steps. Example: `max_value`=3, `HOLD`=0 gives 0,1,2,3,2,1,0,1,…
- `cycle_done` pulses on an accepted step that moves `level` from 0 to 1 out of DOWN or HOLD_BOTTOM. The first 0→1 after reset does not pulse, because it leaves from UP.
- `level` never wraps. All arithmetic is N-bit, and the guards above exclude overflow and underflow.
- PWM:
  - `pwm_cnt` is a free-running N-bit counter that increments each clock with `ena`=1, wrapping 2^N−1→0.
  - `pwm` ← `ena` & (`pwm_cnt` < `level`), using pre-edge values.
  - `level`=0 gives constant 0. `level`=2^N−1 gives 2^N−1 high clocks out of every 2^N.

## Timing
- Step latency is 1 clock: for a step sampled at edge t, the new `level`, `rising` and `cycle_done` are visible after edge t. `cycle_done` drops after edge t+1 unless another qualifying step occurs.
- `pwm` lags the (`pwm_cnt`, `level`) comparison by one clock.
- While `ena`=0, `pwm` is driven to 0 after the next edge. All other registers hold their values.
- If `rst` is asserted mid-sequence, the next edge returns every register to its reset value regardless of `step` or `ena`.
- Back-to-back steps (`step` high on consecutive clocks) are legal, and each one is accepted.

## Test plan
- Reset/idle: assert `rst` with `step`=1 and `ena`=1 → after the edge, `level`=0, `pwm`=0, `cycle_done`=0, `rising`=1.
- Basic triangle: `max_value`=3, `HOLD`=0, step every 4 clocks for 14 steps → `level` = 1,2,3,2,1,0,1,2,3,2,1,0,1,2. `cycle_done` pulses exactly twice, on the 7th and 13th steps.
- Dwell: `HOLD`=2, `max_value`=2, step every clock → `level` = 1,2,2,2,1,0,0,0,1. `rising` falls on the step producing the first 1 after the peak.
- Clamp: `max_value`=10, run to `level`=8 while rising, then set `max_value`=5 and step → `level`=5 and state HOLD_TOP (or DOWN with `level` descending 4,3 when `HOLD`=0).
- Enable freeze: drop `ena` for 20 clocks with steps present → `level`, `pwm_cnt` and the state are unchanged and `pwm`=0. After re-enable, the sequence continues from the same point.
- PWM duty: N=4, hold `level`=5 (`max_value`=5, stop stepping) → exactly 5 high clocks of `pwm` per 16 clocks. With `level`=0 → `pwm` is never high.
